cgra_pkt_gearbox: RTL and testbench

//  Parametrised full-duplex width converter between DMA AXI-Stream beats and whole CGRA packets.
//  RX path (mem->CGRA): packs N_BEATS beats into one PKT_W packet. TX path (CGRA->mem): splits a packet into beats.

---
 rtl/acc_soc_pkg.sv | 28 ++
 rtl/cgra_pkt_deser.sv | 120 ++++++++++++
 rtl/cgra_pkt_gearbox.sv | 141 ++++++++++++++
 tb/tb_cgra_pkt_gearbox.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/acc_soc_pkg.sv
// ---------------------------------------------------------------------------
// acc_soc_pkg
//   Shared constants and helpers for the accelerator SoC stream plumbing.
//   CGRA_PKT_W  : width of one CGRA packet in bits
//   DMA_BEAT_W  : width of one DMA AXI-Stream beat in bits
//   n_beats()   : number of beats needed to carry one packet
//   idx_w()     : width of a beat index able to count 0..n-1 (at least 1)
//   rx_state_e  : state of the RX deserializer framing FSM
// ---------------------------------------------------------------------------
package acc_soc_pkg;

  localparam int CGRA_PKT_W = 185;
  localparam int DMA_BEAT_W = 64;

  function automatic int n_beats(input int pkt_w, input int beat_w);
    return (pkt_w + beat_w - 1) / beat_w;
  endfunction

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef enum logic {
    RX_ASM    = 1'b0,  // assembling beats into a packet
    RX_RESYNC = 1'b1   // dropping beats until a TLAST beat is seen
  } rx_state_e;

endpackage

// File: rtl/cgra_pkt_deser.sv
// ---------------------------------------------------------------------------
// cgra_pkt_deser
//   RX half of the gearbox: packs N_BEATS stream beats (little-endian, beat k
//   carries packet bits [k*BEAT_W +: BEAT_W]) into one PKT_W packet.
//   Checks TLAST framing, checks the pad bits of the final beat, and resyncs
//   to the next TLAST after a missing-TLAST error.
// Ports
//   clk, rstn          clock, asynchronous active-low reset
//   flush              synchronous clear (drops partial / held packet)
//   s_valid/ready/data/last   beat input
//   m_valid/ready/data        packet output, data held stable until popped
//   err_trunc          1-cycle pulse: packet dropped on a framing error
//   err_pad            1-cycle pulse: nonzero pad bits on a delivered packet
// ---------------------------------------------------------------------------
module cgra_pkt_deser
  import acc_soc_pkg::*;
#(
  parameter int PKT_W    = CGRA_PKT_W,
  parameter int BEAT_W   = DMA_BEAT_W,
  parameter int CHK_LAST = 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              flush,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [BEAT_W-1:0] s_data,
  input  logic              s_last,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [PKT_W-1:0]  m_data,
  output logic              err_trunc,
  output logic              err_pad
);

  localparam int N_BEATS = n_beats(PKT_W, BEAT_W);
  localparam int IX_W    = idx_w(N_BEATS);
  // The final beat only carries LAST_W packet bits starting at LAST_LO.
  localparam int LAST_LO = (N_BEATS - 1) * BEAT_W;
  localparam int LAST_W  = PKT_W - LAST_LO;
  localparam logic [IX_W-1:0] LAST_IX = IX_W'(N_BEATS - 1);
  localparam bit CHK = (CHK_LAST != 0);

  rx_state_e         state;
  logic [IX_W-1:0]   rix;
  logic [PKT_W-1:0]  asm_q;
  logic              beat_hs;
  logic              is_final;
  logic              pad_nz;

  // A beat may enter whenever the output slot is empty or being emptied this
  // cycle, so the final beat's write and the next packet's beat 0 can overlap
  // with the pop without losing throughput.
  assign s_ready  = ~m_valid | m_ready;
  assign beat_hs  = s_valid & s_ready;
  assign is_final = (rix == LAST_IX);
  assign m_data   = asm_q;

  if (LAST_W < BEAT_W) begin : g_pad
    assign pad_nz = |s_data[BEAT_W-1:LAST_W];
  end else begin : g_nopad
    assign pad_nz = 1'b0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= RX_ASM;
      rix       <= '0;
      asm_q     <= '0;
      m_valid   <= 1'b0;
      err_trunc <= 1'b0;
      err_pad   <= 1'b0;
    end else if (flush) begin
      state     <= RX_ASM;
      rix       <= '0;
      m_valid   <= 1'b0;
      err_trunc <= 1'b0;
      err_pad   <= 1'b0;
    end else begin
      err_trunc <= 1'b0;
      err_pad   <= 1'b0;
      if (m_valid && m_ready) m_valid <= 1'b0;
      if (beat_hs) begin
        case (state)
          RX_ASM: begin
            if (CHK && s_last && !is_final) begin
              // Packet ended early: drop it, the next beat starts a new one.
              rix       <= '0;
              err_trunc <= 1'b1;
            end else if (CHK && !s_last && is_final) begin
              // Packet ran long: drop it and skip to the end of this frame.
              rix       <= '0;
              err_trunc <= 1'b1;
              state     <= RX_RESYNC;
            end else begin
              for (int k = 0; k < N_BEATS - 1; k++) begin
                if (rix == IX_W'(k)) asm_q[k*BEAT_W +: BEAT_W] <= s_data;
              end
              if (is_final) begin
                // Pad bits are simply not stored, which strips them.
                asm_q[PKT_W-1:LAST_LO] <= s_data[LAST_W-1:0];
                m_valid <= 1'b1;
                err_pad <= pad_nz;
                rix     <= '0;
              end else begin
                rix <= rix + 1'b1;
              end
            end
          end
          RX_RESYNC: begin
            // The TLAST beat itself belongs to the bad frame and is dropped.
            if (s_last) state <= RX_ASM;
          end
          default: state <= RX_ASM;
        endcase
      end
    end
  end

endmodule

// File: rtl/cgra_pkt_gearbox.sv
// ---------------------------------------------------------------------------
// cgra_pkt_gearbox
//   Full-duplex width converter between DMA AXI-Stream beats and whole CGRA
//   packets. RX (mem->CGRA) packs N_BEATS beats into one packet via
//   cgra_pkt_deser; TX (CGRA->mem) splits a packet into beats inline.
//   The two directions share nothing but clock, reset and flush.
// Ports
//   clk, rstn                         clock, asynchronous active-low reset
//   flush                             synchronous clear of both paths
//   s_beat_valid/ready/data/last      RX beats from DMA
//   m_pkt_valid/ready/data            RX packets to the CGRA bridge
//   s_pkt_valid/ready/data            TX packets from the CGRA bridge
//   m_beat_valid/ready/data/last      TX beats to DMA
//   err_trunc, err_pad                RX error pulses
//   rx_pkt_cnt, tx_pkt_cnt            wrapping packet counters
//
// Handshake semantics (all four interfaces): a transfer happens on a rising
// clk edge where valid & ready are both 1. A source holds valid and data
// stable until the transfer; valid never depends combinationally on ready.
// Ready may depend on the downstream ready of the same direction only.
// ---------------------------------------------------------------------------
module cgra_pkt_gearbox
  import acc_soc_pkg::*;
#(
  parameter int PKT_W    = CGRA_PKT_W,
  parameter int BEAT_W   = DMA_BEAT_W,
  parameter int CHK_LAST = 1,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              flush,
  input  logic              s_beat_valid,
  output logic              s_beat_ready,
  input  logic [BEAT_W-1:0] s_beat_data,
  input  logic              s_beat_last,
  output logic              m_pkt_valid,
  input  logic              m_pkt_ready,
  output logic [PKT_W-1:0]  m_pkt_data,
  input  logic              s_pkt_valid,
  output logic              s_pkt_ready,
  input  logic [PKT_W-1:0]  s_pkt_data,
  output logic              m_beat_valid,
  input  logic              m_beat_ready,
  output logic [BEAT_W-1:0] m_beat_data,
  output logic              m_beat_last,
  output logic              err_trunc,
  output logic              err_pad,
  output logic [CNT_W-1:0]  rx_pkt_cnt,
  output logic [CNT_W-1:0]  tx_pkt_cnt
);

  localparam int N_BEATS = n_beats(PKT_W, BEAT_W);
  localparam int IX_W    = idx_w(N_BEATS);
  localparam int LAST_LO = (N_BEATS - 1) * BEAT_W;
  localparam logic [IX_W-1:0] LAST_IX = IX_W'(N_BEATS - 1);

  // ---------------- RX path ----------------
  cgra_pkt_deser #(
    .PKT_W    (PKT_W),
    .BEAT_W   (BEAT_W),
    .CHK_LAST (CHK_LAST)
  ) u_deser (
    .clk       (clk),
    .rstn      (rstn),
    .flush     (flush),
    .s_valid   (s_beat_valid),
    .s_ready   (s_beat_ready),
    .s_data    (s_beat_data),
    .s_last    (s_beat_last),
    .m_valid   (m_pkt_valid),
    .m_ready   (m_pkt_ready),
    .m_data    (m_pkt_data),
    .err_trunc (err_trunc),
    .err_pad   (err_pad)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_pkt_cnt <= '0;
    end else if (flush) begin
      rx_pkt_cnt <= '0;
    end else if (m_pkt_valid && m_pkt_ready) begin
      rx_pkt_cnt <= rx_pkt_cnt + 1'b1;
    end
  end

  // ---------------- TX path ----------------
  logic [PKT_W-1:0] tx_buf;
  logic [IX_W-1:0]  tix;
  logic             tx_final;
  logic             pkt_hs;
  logic             beat_hs;

  assign tx_final = (tix == LAST_IX);
  // A new packet is taken while the last beat of the current one leaves, so
  // back-to-back packets stream without a bubble.
  assign s_pkt_ready = ~m_beat_valid | (m_beat_ready & tx_final);
  assign pkt_hs      = s_pkt_valid & s_pkt_ready;
  assign beat_hs     = m_beat_valid & m_beat_ready;
  assign m_beat_last = tx_final;

  // Beat select; the final beat is zero-extended so pad bits go out as 0.
  always_comb begin
    m_beat_data = '0;
    for (int k = 0; k < N_BEATS - 1; k++) begin
      if (tix == IX_W'(k)) m_beat_data = tx_buf[k*BEAT_W +: BEAT_W];
    end
    if (tx_final) m_beat_data = BEAT_W'(tx_buf[PKT_W-1:LAST_LO]);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tx_buf       <= '0;
      tix          <= '0;
      m_beat_valid <= 1'b0;
      tx_pkt_cnt   <= '0;
    end else if (flush) begin
      tix          <= '0;
      m_beat_valid <= 1'b0;
      tx_pkt_cnt   <= '0;
    end else begin
      if (beat_hs) begin
        if (tx_final) begin
          tix          <= '0;
          m_beat_valid <= 1'b0;
          tx_pkt_cnt   <= tx_pkt_cnt + 1'b1;
        end else begin
          tix <= tix + 1'b1;
        end
      end
      // Accepting a packet overrides the end-of-packet clear above.
      if (pkt_hs) begin
        tx_buf       <= s_pkt_data;
        tix          <= '0;
        m_beat_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cgra_pkt_gearbox.sv
// ---------------------------------------------------------------------------
// tb_cgra_pkt_gearbox
//   Scoreboard bench for cgra_pkt_gearbox with PKT_W=185, BEAT_W=64.
//   Drivers push expected packets/beats into queues; negedge monitors pop and
//   compare whenever the DUT completes an output handshake.
// ---------------------------------------------------------------------------
module tb_cgra_pkt_gearbox;

  localparam int PKT_W   = 185;
  localparam int BEAT_W  = 64;
  localparam int N_BEATS = 3;
  localparam int FULL_W  = N_BEATS * BEAT_W;
  localparam int CNT_W   = 16;

  // ---------------- clock / reset / DUT ----------------
  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              flush = 1'b0;
  logic              s_beat_valid = 1'b0;
  logic              s_beat_ready;
  logic [BEAT_W-1:0] s_beat_data = '0;
  logic              s_beat_last = 1'b0;
  logic              m_pkt_valid;
  logic              m_pkt_ready;
  logic [PKT_W-1:0]  m_pkt_data;
  logic              s_pkt_valid = 1'b0;
  logic              s_pkt_ready;
  logic [PKT_W-1:0]  s_pkt_data = '0;
  logic              m_beat_valid;
  logic              m_beat_ready;
  logic [BEAT_W-1:0] m_beat_data;
  logic              m_beat_last;
  logic              err_trunc;
  logic              err_pad;
  logic [CNT_W-1:0]  rx_pkt_cnt;
  logic [CNT_W-1:0]  tx_pkt_cnt;

  always #5 clk = ~clk;

  cgra_pkt_gearbox #(
    .PKT_W    (PKT_W),
    .BEAT_W   (BEAT_W),
    .CHK_LAST (1),
    .CNT_W    (CNT_W)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .flush        (flush),
    .s_beat_valid (s_beat_valid),
    .s_beat_ready (s_beat_ready),
    .s_beat_data  (s_beat_data),
    .s_beat_last  (s_beat_last),
    .m_pkt_valid  (m_pkt_valid),
    .m_pkt_ready  (m_pkt_ready),
    .m_pkt_data   (m_pkt_data),
    .s_pkt_valid  (s_pkt_valid),
    .s_pkt_ready  (s_pkt_ready),
    .s_pkt_data   (s_pkt_data),
    .m_beat_valid (m_beat_valid),
    .m_beat_ready (m_beat_ready),
    .m_beat_data  (m_beat_data),
    .m_beat_last  (m_beat_last),
    .err_trunc    (err_trunc),
    .err_pad      (err_pad),
    .rx_pkt_cnt   (rx_pkt_cnt),
    .tx_pkt_cnt   (tx_pkt_cnt)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [PKT_W-1:0]  rx_exp_q[$];
  logic [BEAT_W:0]   tx_exp_q[$];   // {last, data}
  logic [PKT_W-1:0]  rx_e;
  logic [BEAT_W:0]   tx_e;
  logic [PKT_W-1:0]  last_rx_pkt = '0;
  int                rx_sent = 0;
  int                tx_sent = 0;
  int                trunc_seen = 0;
  int                pad_seen = 0;
  int                cyc = 0;
  bit                rdy_mode = 1'b0;   // 0: readies high, 1: random
  bit                tx_gap_chk = 1'b0;
  bit                tx_have_prev = 1'b0;
  int                tx_prev_cyc = 0;
  bit                rx_hold_v = 1'b0;
  logic [PKT_W-1:0]  rx_hold_d = '0;
  bit                tx_hold_v = 1'b0;
  logic [BEAT_W:0]   tx_hold_d = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rstn) begin
      // RX packet output
      if (rx_hold_v && m_pkt_valid) check("rx_stable", 256'(m_pkt_data), 256'(rx_hold_d));
      if (m_pkt_valid && m_pkt_ready && !flush) begin
        if (rx_exp_q.size() == 0) begin
          check("rx_extra_pkt", 256'(1), 256'(0));
        end else begin
          rx_e = rx_exp_q.pop_front();
          check("rx_pkt", 256'(m_pkt_data), 256'(rx_e));
        end
        last_rx_pkt = m_pkt_data;
      end
      rx_hold_v = m_pkt_valid && !m_pkt_ready && !flush;
      rx_hold_d = m_pkt_data;

      // TX beat output
      if (tx_hold_v && m_beat_valid)
        check("tx_stable", 256'({m_beat_last, m_beat_data}), 256'(tx_hold_d));
      if (m_beat_valid && m_beat_ready && !flush) begin
        if (tx_exp_q.size() == 0) begin
          check("tx_extra_beat", 256'(1), 256'(0));
        end else begin
          tx_e = tx_exp_q.pop_front();
          check("tx_beat", 256'({m_beat_last, m_beat_data}), 256'(tx_e));
        end
        if (tx_gap_chk && tx_have_prev) check("tx_nogap", 256'(cyc - tx_prev_cyc), 256'(1));
        tx_prev_cyc  = cyc;
        tx_have_prev = tx_gap_chk;
      end
      if (!tx_gap_chk) tx_have_prev = 1'b0;
      tx_hold_v = m_beat_valid && !m_beat_ready && !flush;
      tx_hold_d = {m_beat_last, m_beat_data};

      if (err_trunc) trunc_seen++;
      if (err_pad) pad_seen++;
    end
  end

  // ---------------- ready driver ----------------
  initial begin
    m_pkt_ready  = 1'b1;
    m_beat_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode) begin
        m_pkt_ready  = ($urandom_range(0, 9) < 6);
        m_beat_ready = ($urandom_range(0, 9) < 6);
      end else begin
        m_pkt_ready  = 1'b1;
        m_beat_ready = 1'b1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [PKT_W-1:0] rand_pkt();
    logic [223:0] t;
    for (int i = 0; i < 7; i++) t[i*32 +: 32] = $urandom();
    return t[PKT_W-1:0];
  endfunction

  task automatic rx_beat(input logic [BEAT_W-1:0] d, input logic last);
    bit hs = 1'b0;
    int n = 0;
    s_beat_valid = 1'b1;
    s_beat_data  = d;
    s_beat_last  = last;
    while (!hs && n < 2000) begin
      @(negedge clk);
      hs = s_beat_ready;
      step();
      n++;
    end
    if (!hs) check("rx_beat_timeout", 256'(0), 256'(1));
  endtask

  task automatic rx_idle(input int gap);
    if (gap > 0) begin
      s_beat_valid = 1'b0;
      repeat (gap) step();
    end
  endtask

  task automatic rx_pkt(input logic [PKT_W-1:0] p, input int gap_max);
    logic [FULL_W-1:0] full;
    full = FULL_W'(p);
    for (int k = 0; k < N_BEATS; k++) begin
      rx_beat(full[k*BEAT_W +: BEAT_W], (k == N_BEATS - 1));
      if (k == N_BEATS - 1) begin
        rx_exp_q.push_back(p);
        rx_sent++;
      end
      rx_idle($urandom_range(0, gap_max));
    end
  endtask

  task automatic tx_pkt(input logic [PKT_W-1:0] p, input int gap_max);
    logic [FULL_W-1:0] full;
    bit hs = 1'b0;
    int n = 0;
    int gap;
    full = FULL_W'(p);
    s_pkt_valid = 1'b1;
    s_pkt_data  = p;
    while (!hs && n < 2000) begin
      @(negedge clk);
      hs = s_pkt_ready;
      step();
      n++;
    end
    if (!hs) check("tx_pkt_timeout", 256'(0), 256'(1));
    for (int k = 0; k < N_BEATS; k++)
      tx_exp_q.push_back({(k == N_BEATS - 1) ? 1'b1 : 1'b0, full[k*BEAT_W +: BEAT_W]});
    tx_sent++;
    gap = $urandom_range(0, gap_max);
    if (gap > 0) begin
      s_pkt_valid = 1'b0;
      repeat (gap) step();
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((rx_exp_q.size() != 0 || tx_exp_q.size() != 0) && n < 5000) begin
      step();
      n++;
    end
    if (rx_exp_q.size() != 0 || tx_exp_q.size() != 0) begin
      check("drain_timeout", 256'(0), 256'(1));
      rx_exp_q.delete();
      tx_exp_q.delete();
    end
    repeat (3) step();
  endtask

  // ---------------- main sequence ----------------
  localparam logic [PKT_W-1:0] P0 = {57'h1800001c000011, 64'h4f00238d10000000, 64'h100000};

  initial begin
    logic [BEAT_W-1:0] b0, b1;
    logic [PKT_W-1:0]  fp;

    // Reset state
    repeat (3) step();
    check("rst_s_beat_ready", 256'(s_beat_ready), 256'(1));
    check("rst_s_pkt_ready", 256'(s_pkt_ready), 256'(1));
    rstn = 1'b1;
    step();
    check("rst_m_pkt_valid", 256'(m_pkt_valid), 256'(0));
    check("rst_m_beat_valid", 256'(m_beat_valid), 256'(0));
    check("rst_m_pkt_data", 256'(m_pkt_data), 256'(0));
    check("rst_m_beat_data", 256'(m_beat_data), 256'(0));
    check("rst_m_beat_last", 256'(m_beat_last), 256'(0));
    check("rst_err", 256'({err_trunc, err_pad}), 256'(0));
    check("rst_rx_cnt", 256'(rx_pkt_cnt), 256'(0));
    check("rst_tx_cnt", 256'(tx_pkt_cnt), 256'(0));

    // Directed RX packet
    rx_pkt(P0, 0);
    s_beat_valid = 1'b0;
    wait_drain();
    check("rx_first_pkt", 256'(last_rx_pkt), 256'(P0));
    check("rx_cnt_1", 256'(rx_pkt_cnt), 256'(1));

    // Directed TX: same packet then 4 back-to-back, all beats contiguous
    tx_gap_chk = 1'b1;
    tx_pkt(P0, 0);
    for (int i = 0; i < 4; i++) tx_pkt(rand_pkt(), 0);
    s_pkt_valid = 1'b0;
    wait_drain();
    tx_gap_chk = 1'b0;
    check("tx_cnt_5", 256'(tx_pkt_cnt), 256'(5));

    // Early TLAST on beat 2: drop, one pulse, next packet fine
    rx_beat(64'h1111, 1'b0);
    rx_beat(64'h2222, 1'b1);
    rx_idle(3);
    check("trunc_early_pulse", 256'(trunc_seen), 256'(1));
    check("trunc_no_pkt", 256'(m_pkt_valid), 256'(0));
    rx_pkt(rand_pkt(), 0);
    // Missing TLAST on beat 3: drop, resync until TLAST, one pulse only
    rx_beat(64'h3333, 1'b0);
    rx_beat(64'h4444, 1'b0);
    rx_beat(64'h5555, 1'b0);
    rx_beat(64'h6666, 1'b0);
    rx_beat(64'h7777, 1'b1);
    rx_pkt(rand_pkt(), 0);
    s_beat_valid = 1'b0;
    wait_drain();
    check("trunc_resync_pulses", 256'(trunc_seen), 256'(2));
    check("rx_cnt_after_trunc", 256'(rx_pkt_cnt), 256'(rx_sent));

    // Pad bits set on the final beat
    b0 = 64'hdead_beef_0123_4567;
    b1 = 64'h89ab_cdef_fedc_ba98;
    rx_beat(b0, 1'b0);
    rx_beat(b1, 1'b0);
    rx_beat(64'hFE00_0000_0000_0011, 1'b1);
    rx_exp_q.push_back({57'h11, b1, b0});
    rx_sent++;
    s_beat_valid = 1'b0;
    wait_drain();
    check("pad_pulse", 256'(pad_seen), 256'(1));
    check("pad_stripped", 256'(last_rx_pkt[184:128]), 256'(57'h11));

    // Random traffic with stalls on both directions
    rdy_mode = 1'b1;
    fork
      begin
        for (int i = 0; i < 200; i++) rx_pkt(rand_pkt(), 2);
        s_beat_valid = 1'b0;
      end
      begin
        for (int i = 0; i < 200; i++) tx_pkt(rand_pkt(), 2);
        s_pkt_valid = 1'b0;
      end
    join
    rdy_mode = 1'b0;
    wait_drain();
    check("rx_cnt_random", 256'(rx_pkt_cnt), 256'(rx_sent));
    check("tx_cnt_random", 256'(tx_pkt_cnt), 256'(tx_sent));

    // Flush mid-packet on both paths (RX after 1 beat, TX at tix=1)
    fp = rand_pkt();
    s_pkt_valid  = 1'b1;
    s_pkt_data   = fp;
    s_beat_valid = 1'b1;
    s_beat_data  = 64'habcd;
    s_beat_last  = 1'b0;
    step();
    for (int k = 0; k < N_BEATS; k++)
      tx_exp_q.push_back({(k == N_BEATS - 1) ? 1'b1 : 1'b0, fp[k*BEAT_W +: BEAT_W]});
    s_pkt_valid  = 1'b0;
    s_beat_valid = 1'b0;
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_m_pkt_valid", 256'(m_pkt_valid), 256'(0));
    check("flush_m_beat_valid", 256'(m_beat_valid), 256'(0));
    check("flush_rx_cnt", 256'(rx_pkt_cnt), 256'(0));
    check("flush_tx_cnt", 256'(tx_pkt_cnt), 256'(0));
    check("flush_tx_left", 256'(tx_exp_q.size()), 256'(2));
    tx_exp_q.delete();
    rx_sent = 0;
    tx_sent = 0;
    fork
      begin
        rx_pkt(rand_pkt(), 0);
        s_beat_valid = 1'b0;
      end
      begin
        tx_pkt(rand_pkt(), 0);
        s_pkt_valid = 1'b0;
      end
    join
    wait_drain();
    check("post_flush_rx_cnt", 256'(rx_pkt_cnt), 256'(1));
    check("post_flush_tx_cnt", 256'(tx_pkt_cnt), 256'(1));
    check("final_trunc_pulses", 256'(trunc_seen), 256'(2));
    check("final_pad_pulses", 256'(pad_seen), 256'(1));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
